nand_flash_page_ctrl: RTL and testbench
=======================================

// Module: nand_flash_page_ctrl
// PURPOSE
//  Page-level command controller directly upstream of the byte-wide NAND flash array.
//  Accepts host READ/PROGRAM/ERASE commands on a page address.
//  Sequences one array access per cycle on mem_we/mem_re/mem_addr/mem_wdata.
//  Returns read bytes from mem_rdata on a streaming output port.
// PARAMETERS
//  ADDR_W      8      array byte-address width
//  DATA_W      8      data width
//  PAGE_BYTES  16     bytes per page; power of 2; PAGE_W = ADDR_W - log2(PAGE_BYTES)
//  ERASE_VAL   8'hFF  value written to every byte by ERASE
// PORTS
//  clk         in   1        single clock, rising edge
//  rst_n       in   1        asynchronous active-low reset
//  cmd_valid   in   1        command request
//  cmd_ready   out  1        high only in IDLE; command accepted when cmd_valid & cmd_ready
//  cmd_op      in   2        00 NOP, 01 READ, 10 PROGRAM, 11 ERASE
//  cmd_page    in   PAGE_W   target page
//  wr_valid    in   1        PROGRAM data beat valid
//  wr_ready    out  1        high only in PROG state
//  wr_data     in   DATA_W   PROGRAM data
//  rd_valid    out  1        read byte valid; no backpressure
//  rd_data     out  DATA_W   read byte
//  rd_last     out  1        marks last byte of the page
//  busy        out  1        state != IDLE
//  done        out  1        one-cycle pulse when a command completes
//  status_err  out  1        verify mismatch; see CONFIGURATION
//  mem_we/mem_re  out  1     array write / read enables; never both high
//  mem_addr    out  ADDR_W   {page, byte_cnt}
//  mem_wdata   out  DATA_W   array write data
//  mem_rdata   in   DATA_W   array read data; valid 1 cycle after mem_re; 0 when re was low
// BEHAVIOUR
//  - Reset: all outputs 0 except cmd_ready=1; state IDLE; counters 0.
//  - States: IDLE, READ, PROG, ERASE, VERIFY (macro only), DONE.
//  - Accept at cycle T: latch op and page; byte_cnt=0; next state depends on op.
//  - NOP: DONE at T+1, done=1 at T+1, IDLE at T+2; no array access.
//  - READ: mem_re=1 at T+1..T+PAGE_BYTES with byte_cnt 0..PAGE_BYTES-1.
//    rd_valid/rd_data one cycle later (T+2..T+PAGE_BYTES+1), registered from mem_rdata.
//    rd_last and done both pulse with the final rd_valid.
//  - PROG: each cycle with wr_valid & wr_ready: mem_we=1, mem_wdata=wr_data, byte_cnt++.
//    wr_valid low -> stall; no write; address held.
//    After beat PAGE_BYTES-1: DONE; done=1 the cycle after the last beat.
//  - ERASE: mem_we=1 with ERASE_VAL for PAGE_BYTES consecutive cycles; then DONE.
//  - byte_cnt wraps to 0 at PAGE_BYTES-1. Page bits never change mid-command.
//  - cmd_valid while busy: ignored; cmd_ready=0; no queuing.
//    A new command is accepted no earlier than the cycle after done.
//  - Reset mid-command: abort immediately; no further array access.
//    Array contents already written remain. rd_valid/done are not emitted.
// CONFIGURATION
//  Macro NAND_WRITE_VERIFY_EN.
//  - Defined:
//    - PROG also stores beats in a PAGE_BYTES x DATA_W page buffer.
//    - PROG and ERASE continue to VERIFY: mem_re over the page, and each returned
//      byte is compared with the buffer (PROG) or ERASE_VAL (ERASE).
//    - Any mismatch sets status_err. status_err stays set until the next command accept.
//    - done pulses with the final compare. rd_valid stays 0 during VERIFY.
//  - Undefined: no buffer, no VERIFY state; status_err tied to 0.
// STRUCTURE
//  - Package nand_flash_pkg: cmd_op encodings (OP_NOP/OP_READ/OP_PROG/OP_ERASE),
//    state enum, and PAGE_W/CNT_W localparams.
//  - Sub-module nand_page_buffer: register array for the verify build only;
//    write port indexed by byte_cnt, async read port.
// TESTING
//  - Reset, then ERASE page 3 -> mem_we 16 cycles, addr 0x30..0x3F, wdata FF; done at cycle 17.
//  - PROGRAM page 3 with 0x00..0x0F, wr_valid dropped on beats 4 and 9 ->
//    no writes during stalls; mem 0x30..0x3F = 00..0F.
//  - READ page 3 -> rd_valid 16 consecutive cycles, data 00..0F; rd_last and done on byte 0F.
//  - cmd_valid held during READ busy -> cmd_ready=0; second command accepted only after done.
//  - rst_n pulled low at PROGRAM beat 5 -> outputs reset asynchronously;
//    only bytes 0..4 written; next READ returns 00..04 followed by old data.
//  - With NAND_WRITE_VERIFY_EN, force mem_rdata bit flip on byte 7 ->
//    status_err=1 with done; cleared on the next command accept.

Source files
------------

// File: rtl/nand_flash_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : nand_flash_pkg
//  Description : Shared definitions for the NAND flash page controller:
//                host command encodings, controller state encoding and the
//                default geometry (page/byte-counter widths).
//  Optional    : NAND_WRITE_VERIFY_EN (consumers only; nothing here changes)
//  Revision    : 1.0 - initial release
// ============================================================================
package nand_flash_pkg;

    localparam int DEF_ADDR_W     = 8;
    localparam int DEF_DATA_W     = 8;
    localparam int DEF_PAGE_BYTES = 16;

    // Byte-within-page counter width and page-number width for the default geometry.
    localparam int CNT_W  = $clog2(DEF_PAGE_BYTES);
    localparam int PAGE_W = DEF_ADDR_W - CNT_W;

    typedef enum logic [1:0] {
        OP_NOP   = 2'b00,
        OP_READ  = 2'b01,
        OP_PROG  = 2'b10,
        OP_ERASE = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_READ   = 3'd1,
        ST_PROG   = 3'd2,
        ST_ERASE  = 3'd3,
        ST_VERIFY = 3'd4,
        ST_DONE   = 3'd5
    } state_e;

endpackage
`default_nettype wire

// File: rtl/nand_flash_page_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : nand_flash_page_ctrl_if
//  Description : Host-side bundle of the page controller.
//                cmd_*  : command handshake (valid/ready, op, page)
//                wr_*   : PROGRAM data beats (valid/ready, data)
//                rd_*   : read byte stream (valid, data, last; no backpressure)
//                busy/done/status_err : command status
//                master = host side, slave = controller side.
//  Revision    : 1.0 - initial release
// ============================================================================
interface nand_flash_page_ctrl_if
    import nand_flash_pkg::*;
#(
    parameter int CMD_PAGE_W = PAGE_W,
    parameter int DATA_W     = DEF_DATA_W
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [1:0]            cmd_op;
    logic [CMD_PAGE_W-1:0] cmd_page;
    logic                  wr_valid;
    logic                  wr_ready;
    logic [DATA_W-1:0]     wr_data;
    logic                  rd_valid;
    logic [DATA_W-1:0]     rd_data;
    logic                  rd_last;
    logic                  busy;
    logic                  done;
    logic                  status_err;

    modport master (
        output cmd_valid, cmd_op, cmd_page, wr_valid, wr_data,
        input  cmd_ready, wr_ready, rd_valid, rd_data, rd_last, busy, done, status_err
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_page, wr_valid, wr_data,
        output cmd_ready, wr_ready, rd_valid, rd_data, rd_last, busy, done, status_err
    );
endinterface
`default_nettype wire

// File: rtl/nand_page_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : nand_page_buffer
//  Description : One-page register array holding the PROGRAM beats so the
//                verify pass can compare read-back data against them.
//                Only present when NAND_WRITE_VERIFY_EN is defined.
//  Ports       : clk          clock
//                we/waddr/wdata  synchronous write port (indexed by byte count)
//                raddr/rdata     asynchronous read port
//  Revision    : 1.0 - initial release
// ============================================================================
`ifdef NAND_WRITE_VERIFY_EN
module nand_page_buffer #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16
)(
    input  wire logic                     clk,
    input  wire logic                     we,
    input  wire logic [$clog2(DEPTH)-1:0] waddr,
    input  wire logic [DATA_W-1:0]        wdata,
    input  wire logic [$clog2(DEPTH)-1:0] raddr,
    output logic      [DATA_W-1:0]        rdata
);
    // Storage only; contents are always rewritten before being compared, so no reset.
    logic [DATA_W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    assign rdata = r_mem[raddr];
endmodule
`endif
`default_nettype wire

// File: rtl/nand_flash_page_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : nand_flash_page_ctrl
//  Description : Page-level READ / PROGRAM / ERASE sequencer in front of a
//                byte-wide NAND array; one array access per cycle.
//  Ports       : clk, rst_n (async, active low)
//                host  : nand_flash_page_ctrl_if.slave (command, write beats,
//                        read stream, busy/done/status_err)
//                mem_we/mem_re/mem_addr/mem_wdata : array access
//                mem_rdata : array read data, valid the cycle after mem_re
//  Optional    : NAND_WRITE_VERIFY_EN - PROGRAM/ERASE are followed by a
//                read-back verify pass that sets status_err on a mismatch.
//  Revision    : 1.0 - initial release
// ============================================================================
module nand_flash_page_ctrl
    import nand_flash_pkg::*;
#(
    parameter int              ADDR_W     = DEF_ADDR_W,
    parameter int              DATA_W     = DEF_DATA_W,
    parameter int              PAGE_BYTES = DEF_PAGE_BYTES,
    parameter logic [DATA_W-1:0] ERASE_VAL = 8'hFF
)(
    input  wire logic                clk,
    input  wire logic                rst_n,
    nand_flash_page_ctrl_if.slave    host,
    output logic                     mem_we,
    output logic                     mem_re,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic [DATA_W-1:0]        mem_wdata,
    input  wire logic [DATA_W-1:0]   mem_rdata
);
    localparam int                 c_cnt_w  = $clog2(PAGE_BYTES);
    localparam int                 c_page_w = ADDR_W - c_cnt_w;
    localparam logic [c_cnt_w-1:0] c_last   = c_cnt_w'(PAGE_BYTES - 1);
`ifdef NAND_WRITE_VERIFY_EN
    localparam state_e             c_after_wr = ST_VERIFY;
`else
    localparam state_e             c_after_wr = ST_DONE;
`endif

    state_e               r_state, w_next;
    logic [c_page_w-1:0]  r_page;
    logic [c_cnt_w-1:0]   r_cnt;
    logic                 r_rd_valid;
    logic                 r_rd_last;
    logic                 w_accept;
    logic                 w_beat;
    logic                 w_cnt_last;
    logic                 w_cnt_step;

    assign w_accept   = host.cmd_valid && (r_state == ST_IDLE);
    assign w_beat     = (r_state == ST_PROG) && host.wr_valid;
    assign w_cnt_last = (r_cnt == c_last);
    assign w_cnt_step = (r_state == ST_READ) || (r_state == ST_ERASE) ||
                        (r_state == ST_VERIFY) || w_beat;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        mem_we    = 1'b0;
        mem_re    = 1'b0;
        mem_wdata = '0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    case (host.cmd_op)
                        OP_READ:  w_next = ST_READ;
                        OP_PROG:  w_next = ST_PROG;
                        OP_ERASE: w_next = ST_ERASE;
                        default:  w_next = ST_DONE;
                    endcase
                end
            end
            ST_READ: begin
                mem_re = 1'b1;
                if (w_cnt_last) w_next = ST_DONE;
            end
            ST_PROG: begin
                // A missing beat is a stall: no write, counter and address hold.
                mem_we    = host.wr_valid;
                mem_wdata = host.wr_valid ? host.wr_data : '0;
                if (host.wr_valid && w_cnt_last) w_next = c_after_wr;
            end
            ST_ERASE: begin
                mem_we    = 1'b1;
                mem_wdata = ERASE_VAL;
                if (w_cnt_last) w_next = c_after_wr;
            end
`ifdef NAND_WRITE_VERIFY_EN
            ST_VERIFY: begin
                mem_re = 1'b1;
                if (w_cnt_last) w_next = ST_DONE;
            end
`endif
            ST_DONE: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    // Counter wraps naturally to 0 after the last byte, so a verify pass
    // following PROG/ERASE starts at byte 0 without an explicit clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_page     <= '0;
            r_cnt      <= '0;
            r_rd_valid <= 1'b0;
            r_rd_last  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_page <= host.cmd_page;
                r_cnt  <= '0;
            end else if (w_cnt_step) begin
                r_cnt <= r_cnt + 1'b1;
            end
            r_rd_valid <= (r_state == ST_READ);
            r_rd_last  <= (r_state == ST_READ) && w_cnt_last;
        end
    end

    assign mem_addr        = {r_page, r_cnt};
    assign host.cmd_ready  = (r_state == ST_IDLE);
    assign host.wr_ready   = (r_state == ST_PROG);
    assign host.busy       = (r_state != ST_IDLE);
    assign host.done       = (r_state == ST_DONE);
    assign host.rd_valid   = r_rd_valid;
    assign host.rd_last    = r_rd_last;
    // The array already returns its data from a register one cycle after
    // mem_re; it is forwarded in that cycle, qualified by the delayed valid.
    assign host.rd_data    = r_rd_valid ? mem_rdata : '0;

`ifdef NAND_WRITE_VERIFY_EN
    logic                r_vfy_pend;
    logic [c_cnt_w-1:0]  r_vfy_idx;
    logic                r_op_prog;
    logic                r_err;
    logic [DATA_W-1:0]   w_buf_rd;
    logic [DATA_W-1:0]   w_vfy_exp;
    logic                w_cmp_fail;

    nand_page_buffer #(
        .DATA_W (DATA_W),
        .DEPTH  (PAGE_BYTES)
    ) u_page_buffer (
        .clk    (clk),
        .we     (w_beat),
        .waddr  (r_cnt),
        .wdata  (host.wr_data),
        .raddr  (r_vfy_idx),
        .rdata  (w_buf_rd)
    );

    assign w_vfy_exp  = r_op_prog ? w_buf_rd : ERASE_VAL;
    assign w_cmp_fail = r_vfy_pend && (mem_rdata != w_vfy_exp);

    // Compare happens the cycle after each verify read, tracking which byte it was.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vfy_pend <= 1'b0;
            r_vfy_idx  <= '0;
            r_op_prog  <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_vfy_pend <= (r_state == ST_VERIFY);
            r_vfy_idx  <= r_cnt;
            if (w_accept) begin
                r_op_prog <= (host.cmd_op == OP_PROG);
                r_err     <= 1'b0;
            end else if (w_cmp_fail) begin
                r_err <= 1'b1;
            end
        end
    end

    // A mismatch on the final byte must still be visible alongside done.
    assign host.status_err = r_err || w_cmp_fail;
`else
    assign host.status_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_nand_flash_page_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_nand_flash_page_ctrl
//  Description : Scoreboard bench for nand_flash_page_ctrl. A behavioural
//                byte-array model stands in for the NAND array; a reference
//                page image predicts read data and array writes.
//  Optional    : NAND_WRITE_VERIFY_EN selects the verify-build expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_nand_flash_page_ctrl;
    import nand_flash_pkg::*;

`ifdef NAND_WRITE_VERIFY_EN
    localparam bit VFY = 1'b1;
`else
    localparam bit VFY = 1'b0;
`endif

    typedef struct packed {
        logic [7:0] d;
        logic       last;
    } rd_t;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b1;
    logic       mem_we, mem_re;
    logic [7:0] mem_addr, mem_wdata;
    logic [7:0] mem_rdata = 8'h00;

    logic [7:0]  arr     [256];
    logic [7:0]  ref_mem [256];
    logic [7:0]  pd      [16];
    bit          inject  = 1'b0;
    rd_t         rd_q [$];
    logic [15:0] wr_q [$];
    rd_t         e_rd;
    logic [15:0] e_wr;
    int          n_cmp = 0;
    int          n_bad = 0;

    nand_flash_page_ctrl_if hif ();

    nand_flash_page_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .host      (hif),
        .mem_we    (mem_we),
        .mem_re    (mem_re),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    // NAND array: registered read data one cycle after mem_re, 0 otherwise.
    always @(posedge clk) begin
        if (mem_we) arr[mem_addr] <= mem_wdata;
        if (mem_re) mem_rdata <= arr[mem_addr] ^ ((inject && mem_addr[3:0] == 4'd7) ? 8'h01 : 8'h00);
        else        mem_rdata <= 8'h00;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: pops expectations whenever the DUT presents a read byte or an array write.
    always @(negedge clk) begin
        if (rst_n) begin
            if (mem_we && mem_re) chk("we_re_exclusive", {mem_we, mem_re}, 2'b00);
            if (hif.rd_valid) begin
                if (rd_q.size() == 0) begin
                    chk("rd_unexpected_valid", hif.rd_valid, 1'b0);
                end else begin
                    e_rd = rd_q.pop_front();
                    chk("rd_data", hif.rd_data, e_rd.d);
                    chk("rd_last", hif.rd_last, e_rd.last);
                end
            end
            if (mem_we) begin
                if (wr_q.size() == 0) begin
                    chk("wr_unexpected", mem_we, 1'b0);
                end else begin
                    e_wr = wr_q.pop_front();
                    chk("wr_addr_data", {mem_addr, mem_wdata}, e_wr);
                end
            end
        end
    end

    task automatic accept_cmd(input logic [1:0] op, input logic [3:0] page);
        bit rdy;
        int n;
        @(posedge clk); #1;
        hif.cmd_valid = 1'b1;
        hif.cmd_op    = op;
        hif.cmd_page  = page;
        n = 0;
        do begin
            @(negedge clk);
            rdy = hif.cmd_ready;
            @(posedge clk); #1;
            n++;
        end while (!rdy && n < 50);
        chk("cmd_accept", rdy, 1'b1);
        hif.cmd_valid = 1'b0;
        hif.cmd_op    = OP_NOP;
    endtask

    // mode 0: no stalls, 1: random stalls, 2: first attempt of beats 4 and 9 dropped.
    task automatic prog_beats(input int mode, input int nbeats, output int cyc);
        int beat;
        bit ok;
        bit [15:0] dropped;
        beat = 0; cyc = 0; dropped = '0;
        while (beat < nbeats && cyc < 400) begin
            hif.wr_data = pd[beat];
            case (mode)
                1:       hif.wr_valid = ($urandom_range(0, 3) != 0);
                2: begin
                    hif.wr_valid = !((beat == 4 || beat == 9) && !dropped[beat]);
                    dropped[beat] = 1'b1;
                end
                default: hif.wr_valid = 1'b1;
            endcase
            @(negedge clk);
            ok = hif.wr_valid && hif.wr_ready;
            @(posedge clk); #1;
            cyc++;
            if (ok) beat++;
        end
        chk("prog_beats_taken", beat, nbeats);
    endtask

    task automatic wait_done(input int exp_cyc, input int cyc0, input bit exp_err);
        int cyc;
        bit got;
        cyc = cyc0; got = 1'b0;
        hif.wr_valid = 1'b0;
        while (!got && cyc < cyc0 + 200) begin
            @(negedge clk);
            cyc++;
            if (hif.done) got = 1'b1;
        end
        chk("done_seen", got, 1'b1);
        if (got) begin
            chk("done_latency", cyc, exp_cyc);
            chk("done_busy", hif.busy, 1'b1);
            chk("status_err_at_done", hif.status_err, exp_err);
        end
    endtask

    task automatic push_read(input logic [3:0] page);
        for (int i = 0; i < 16; i++)
            rd_q.push_back('{d: ref_mem[page*16+i], last: (i == 15)});
    endtask

    task automatic run_cmd(input logic [1:0] op, input logic [3:0] page,
                           input int mode, input bit ramp, input bit inj);
        int nb;
        case (op)
            OP_READ: push_read(page);
            OP_PROG: for (int i = 0; i < 16; i++) begin
                pd[i] = ramp ? 8'(i) : 8'($urandom);
                wr_q.push_back({8'(page*16+i), pd[i]});
                ref_mem[page*16+i] = pd[i];
            end
            OP_ERASE: for (int i = 0; i < 16; i++) begin
                wr_q.push_back({8'(page*16+i), 8'hFF});
                ref_mem[page*16+i] = 8'hFF;
            end
            default: ;
        endcase
        inject = inj;
        accept_cmd(op, page);
        case (op)
            OP_PROG: begin
                prog_beats(mode, 16, nb);
                wait_done(nb + (VFY ? 17 : 1), nb, VFY && inj);
            end
            OP_READ:  wait_done(17, 0, 1'b0);
            OP_ERASE: wait_done(VFY ? 33 : 17, 0, 1'b0);
            default:  wait_done(1, 0, 1'b0);
        endcase
        inject = 1'b0;
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_cmd_ready"}, hif.cmd_ready, 1'b1);
        chk({tag, "_busy"},      hif.busy, 1'b0);
        chk({tag, "_done"},      hif.done, 1'b0);
        chk({tag, "_rd_valid"},  hif.rd_valid, 1'b0);
        chk({tag, "_wr_ready"},  hif.wr_ready, 1'b0);
        chk({tag, "_mem_en"},    {mem_we, mem_re}, 2'b00);
        chk({tag, "_mem_addr"},  mem_addr, 8'h00);
        chk({tag, "_status"},    hif.status_err, 1'b0);
    endtask

    initial begin
        int cyc, bad, nb;
        bit got;
        hif.cmd_valid = 1'b0; hif.cmd_op = OP_NOP; hif.cmd_page = '0;
        hif.wr_valid  = 1'b0; hif.wr_data = '0;
        for (int i = 0; i < 256; i++) begin
            arr[i]     = 8'($urandom);
            ref_mem[i] = arr[i];
        end
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check_idle_outputs("reset");
        @(posedge clk); #1 rst_n = 1'b1;

        // Directed: erase, stalled ramp program, read back.
        run_cmd(OP_ERASE, 4'd3, 0, 1'b0, 1'b0);
        run_cmd(OP_PROG,  4'd3, 2, 1'b1, 1'b0);
        run_cmd(OP_READ,  4'd3, 0, 1'b0, 1'b0);
        run_cmd(OP_NOP,   4'd1, 0, 1'b0, 1'b0);

        // cmd_valid held through a READ: ignored until the cycle after done.
        push_read(4'd3);
        accept_cmd(OP_READ, 4'd3);
        hif.cmd_valid = 1'b1; hif.cmd_op = OP_NOP;
        cyc = 0; got = 1'b0; bad = 0;
        while (!got && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (hif.cmd_ready) bad++;
            if (hif.done) got = 1'b1;
        end
        chk("held_ready_low", bad, 0);
        chk("held_done_latency", cyc, 17);
        @(negedge clk);
        chk("ready_after_done", hif.cmd_ready, 1'b1);
        @(posedge clk); #1;
        hif.cmd_valid = 1'b0;
        wait_done(1, 0, 1'b0);

        // Reset during PROGRAM after five beats: only bytes 0..4 change.
        for (int i = 0; i < 16; i++) pd[i] = 8'($urandom);
        for (int i = 0; i < 5; i++) begin
            wr_q.push_back({8'(48 + i), pd[i]});
            ref_mem[48 + i] = pd[i];
        end
        accept_cmd(OP_PROG, 4'd3);
        prog_beats(0, 5, nb);
        rst_n = 1'b0;
        hif.wr_valid = 1'b0;
        #1;
        check_idle_outputs("async_reset");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        run_cmd(OP_READ, 4'd3, 0, 1'b0, 1'b0);

        // Verify fault on byte 7; status_err held until the next accept.
        run_cmd(OP_PROG, 4'd3, 0, 1'b0, 1'b1);
        @(negedge clk);
        chk("status_err_held", hif.status_err, VFY);
        run_cmd(OP_NOP, 4'd0, 0, 1'b0, 1'b0);
        run_cmd(OP_ERASE, 4'd2, 0, 1'b0, 1'b0);

        // Randomized commands over a few pages so reads observe earlier writes.
        for (int k = 0; k < 24; k++)
            run_cmd(2'($urandom_range(0, 3)), 4'($urandom_range(0, 3)), 1, 1'b0, 1'b0);

        repeat (4) @(negedge clk);
        chk("rd_queue_drained", rd_q.size(), 0);
        chk("wr_queue_drained", wr_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d compared so far", n_cmp);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
